// File: rtl/bullet_fire_sched.sv
// rtl/bullet_fire_sched.sv - player bullet fire scheduler
//
// Sequences the player-bullet datapath: paces shot opportunities with a
// cadence counter, picks a free bullet slot round-robin for each shot and
// runs the single/double power-up mode timer.
//
// Ports:
//   clk_run          game-logic clock
//   rst              asynchronous active-high reset
//   en_i             game running (low = paused / game over)
//   slot_busy_i      per-slot occupancy from the datapath
//   powerup_i        one-cycle double-bullet pickup pulse
//   shoot_o          one-cycle shot pulse
//   shoot_idx_o      slot to load, valid while shoot_o is high
//   mode_o           0 = single, 1 = double
//   powerup_active_o power-up timer running
//   drop_cnt_o       saturating count of shot opportunities lost to a full pool
module bullet_fire_sched #(
    parameter int          BULLET_NUM     = 4,
    parameter int          IDX_W          = 2,
    parameter int unsigned CNT_MAX_SHOOT  = 50000000,
    parameter int          CNT_W          = 26,
    parameter int unsigned POWERUP_CYCLES = 32'd2500000000,
    parameter int          PU_W           = 32
) (
    input  logic                  clk_run,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic [BULLET_NUM-1:0] slot_busy_i,
    input  logic                  powerup_i,
    output logic                  shoot_o,
    output logic [IDX_W-1:0]      shoot_idx_o,
    output logic                  mode_o,
    output logic                  powerup_active_o,
    output logic [7:0]            drop_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CNT_MAX_SHOOT - 1);
    localparam logic [PU_W-1:0]  PU_RELOAD = PU_W'(POWERUP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_COOL = 2'd1,
        S_FIRE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   ptr_next;
    logic [IDX_W-1:0]   idx_next;
    logic               shoot_next;
    logic               drop_inc;
    logic [PU_W-1:0]    timer;

    logic [IDX_W-1:0]   sel;
    logic               sel_found;
    logic               at_decision;

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
        return IDX_W'((int'(base) + off) % BULLET_NUM);
    endfunction

    // Round-robin search starting just after the last slot fired, so a busy
    // slot is skipped rather than stalling the shot.
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        for (int k = 1; k <= BULLET_NUM; k++) begin
            if (!sel_found && !slot_busy_i[wrap_idx(ptr, k)]) begin
                sel       = wrap_idx(ptr, k);
                sel_found = 1'b1;
            end
        end
    end

    assign at_decision = (state == S_COOL) && en_i && (cnt == CNT_LAST);

    // State register
    always_ff @(posedge clk_run or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (en_i) state_next = S_COOL;
            S_COOL: begin
                if (!en_i)                         state_next = S_IDLE;
                else if (at_decision && sel_found) state_next = S_FIRE;
            end
            S_FIRE:  state_next = en_i ? S_COOL : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Action decode; results are registered below so every output is a flop.
    always_comb begin
        cnt_next   = cnt;
        ptr_next   = ptr;
        idx_next   = shoot_idx_o;
        shoot_next = 1'b0;
        drop_inc   = 1'b0;
        case (state)
            S_COOL: begin
                if (en_i) begin
                    if (cnt == CNT_LAST) begin
                        cnt_next = '0;
                        if (sel_found) begin
                            shoot_next = 1'b1;
                            idx_next   = sel;
                            ptr_next   = sel;
                        end else begin
                            drop_inc = 1'b1;
                        end
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            // The fire cycle still counts, keeping the shot period exact.
            S_FIRE: if (en_i) cnt_next = cnt + 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_run or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            ptr         <= IDX_W'(BULLET_NUM - 1);
            shoot_o     <= 1'b0;
            shoot_idx_o <= '0;
            drop_cnt_o  <= 8'd0;
        end else begin
            cnt         <= cnt_next;
            ptr         <= ptr_next;
            shoot_o     <= shoot_next;
            shoot_idx_o <= idx_next;
            if (drop_inc && (drop_cnt_o != 8'hFF)) begin
                drop_cnt_o <= drop_cnt_o + 8'd1;
            end
        end
    end

    // Power-up timer: a pickup always reloads (no stacking) and beats expiry
    // on the same edge; the countdown freezes while the game is paused.
    always_ff @(posedge clk_run or posedge rst) begin
        if (rst) begin
            timer            <= '0;
            powerup_active_o <= 1'b0;
            mode_o           <= 1'b0;
        end else if (powerup_i) begin
            timer            <= PU_RELOAD;
            powerup_active_o <= 1'b1;
            mode_o           <= 1'b1;
        end else if (powerup_active_o && en_i) begin
            if (timer == '0) begin
                powerup_active_o <= 1'b0;
                mode_o           <= 1'b0;
            end else begin
                timer <= timer - 1'b1;
            end
        end
    end

endmodule
